// File: rtl/button_pkg.sv
// button_pkg -- shared types and defaults for the pushbutton conditioner.
//   cond_state_t     : 2-bit conditioner FSM state encoding
//   DEBOUNCE_DEFAULT : default stable-sample count to accept a level change
//   LONG_DEFAULT     : default HELD-cycle count before a long press fires
//   cnt_width()      : counter width able to hold 0..max_val, never below 1 bit
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } cond_state_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 4;
  localparam int unsigned LONG_DEFAULT     = 10;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous level.
//   clk : sampling clock (rising edge)
//   rst : synchronous, active-low reset; both flops clear to 0
//   d   : asynchronous input level
//   q   : synchronized level (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner -- synchronizes and debounces a raw pushbutton and
// produces a single strobe per accepted press.
//   clk         : sole clock, rising edge
//   rst         : synchronous, active-low reset
//   btn_in      : raw bouncing pushbutton level, active-high, asynchronous
//   press_pulse : one-cycle strobe per accepted press
//   btn_level   : debounced level, 1 in HELD or RELEASE_WAIT
//   long_press  : one-cycle strobe after LONG_CYCLES cycles in HELD
//   cond_state  : current FSM state encoding
// Optional feature macro: LONG_PRESS_EN (hold counter and long_press logic);
// when undefined long_press is tied to 0.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned LONG_CYCLES     = LONG_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       press_pulse,
  output logic       btn_level,
  output logic       long_press,
  output logic [1:0] cond_state
);

  localparam int unsigned    DEB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_sync;
  cond_state_t      state, state_nxt;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_sync)
  );

  // deb_cnt stops at DEB_LAST because the state always leaves on that value.
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt   = PRESS_WAIT;
          deb_cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = HELD;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_nxt   = RELEASE_WAIT;
          deb_cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_nxt = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = IDLE;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        deb_cnt_nxt = '0;
      end
    endcase
  end

  // press_pulse and btn_level are decoded from the next state so they line
  // up with the state register on the cycle after the transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      press_pulse <= 1'b0;
      btn_level   <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_cnt_nxt;
      press_pulse <= (state == PRESS_WAIT) && (state_nxt == HELD);
      btn_level   <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
    end
  end

  assign cond_state = state;

`ifdef LONG_PRESS_EN
  localparam int unsigned       HOLD_W   = cnt_width(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;
  logic              long_q;

  // hold_cnt is kept through RELEASE_WAIT and saturates, so a release glitch
  // resumes counting without re-firing once the strobe has been issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (state == IDLE) begin
        hold_cnt <= '0;
      end else if ((state == HELD) && (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + 1'b1;
        long_q   <= (hold_cnt == HOLD_MAX - 1'b1);
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;

  // LONG_CYCLES has no hardware here; keep it referenced by a legality guard.
  if (LONG_CYCLES < 1) begin : g_long_cycles_illegal
  end
`endif

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a level change (legal range 1..65535).
REQ-002 SHALL have parameter LONG_CYCLES, default 10: HELD-state cycles before long_press fires (legal range >=1).
REQ-003 SHALL have port clk  input  1  sole clock; all flops on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port btn_in  input  1  raw asynchronous, bouncing pushbutton level, active-high.
REQ-006 SHALL have port press_pulse  output  1  one-cycle strobe per accepted press; drives the button input of the downstream FSM.
REQ-007 SHALL have port btn_level  output  1  debounced level: 1 in HELD or RELEASE_WAIT, else 0.
REQ-008 SHALL have port long_press  output  1  one-cycle strobe on long hold (LONG_PRESS_EN only; otherwise tied 0).
REQ-009 SHALL have port cond_state  output  2  current FSM state encoding.

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer; btn_sync is the second flop's output, and no other logic samples btn_in.
REQ-011 SHALL implement 4 states: IDLE=2'b00, PRESS_WAIT=2'b01, HELD=2'b10, RELEASE_WAIT=2'b11.
REQ-012 IDLE: btn_sync=1 -> PRESS_WAIT with deb_cnt=0; otherwise stay.
REQ-013 PRESS_WAIT: btn_sync=0 -> IDLE, no pulse (bounce rejected); btn_sync=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> HELD; else deb_cnt+1.
REQ-014 HELD: btn_sync=0 -> RELEASE_WAIT with deb_cnt=0; otherwise stay.
REQ-015 RELEASE_WAIT: btn_sync=1 -> HELD, no new press_pulse, hold count preserved; btn_sync=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> IDLE; else deb_cnt+1.
REQ-016 press_pulse SHALL be registered and high exactly for the cycle after the PRESS_WAIT->HELD edge; with edge 0 as the first edge sampling btn_in=1 and btn_in held, the pulse is high after edge DEBOUNCE_CYCLES+2.
REQ-017 SHALL produce at most one press_pulse per IDLE->HELD traversal.
REQ-018 deb_cnt width SHALL be $clog2(DEBOUNCE_CYCLES+1), min 1 bit; it never wraps because REQ-013/015 leave the state at the terminal value.
REQ-019 hold_cnt SHALL clear on IDLE, increment each cycle in HELD, and saturate at LONG_CYCLES; it never wraps.
REQ-020 cond_state and btn_level SHALL be registered outputs, consistent with the state register in the same cycle.

Reset
REQ-021 On rst=0 at a clock edge: state=IDLE, deb_cnt=0, hold_cnt=0, synchronizer flops=0, press_pulse=0, long_press=0, btn_level=0, cond_state=2'b00.
REQ-022 Reset SHALL dominate all other conditions, including mid-debounce and mid-hold, and no pulse is emitted on the cycle reset releases.
REQ-023 After release with btn_in already high, a full debounce (REQ-016 latency) SHALL be required before press_pulse.

Configuration
REQ-024 Macro LONG_PRESS_EN: when defined, hold_cnt and long_press logic are present, and long_press pulses one cycle when hold_cnt reaches LONG_CYCLES, once per press, with no re-fire after RELEASE_WAIT->HELD.
REQ-025 When LONG_PRESS_EN is undefined, hold_cnt SHALL not exist and long_press SHALL be constant 0; all other behaviour is identical.

Structure
REQ-026 Package button_pkg SHALL hold the cond_state_t enum (2-bit, encodings per REQ-011) and the default constants DEBOUNCE_DEFAULT=4 and LONG_DEFAULT=10.
REQ-027 Sub-module sync_2ff (1-bit, clk/rst, reset value 0) SHALL implement REQ-010; all other logic is in button_conditioner.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-028 Clean press: btn_in 0->1 before edge 0, held -> press_pulse=1 only after edge 6, btn_level=1 from the same cycle, cond_state=2'b10.
REQ-029 Bounce: btn_in high 3 cycles, low 1, high 2, then low -> no press_pulse, cond_state returns to 2'b00.
REQ-030 Release glitch: in HELD, btn_in low 2 cycles then high -> cond_state 2'b10->2'b11->2'b10, no second press_pulse, btn_level stays 1.
REQ-031 Long press (LONG_PRESS_EN): hold 20 cycles after press_pulse -> exactly one long_press, 10 cycles after HELD entry; build without the macro -> long_press=0 throughout.
REQ-032 Reset mid-operation: rst=0 for 1 cycle during PRESS_WAIT (deb_cnt=2), btn_in held high -> all outputs 0 next cycle, then press_pulse after edge 6 counted from the first edge after reset release.
REQ-033 Back-to-back: two clean presses separated by 5 low cycles -> exactly two press_pulses; 3 low cycles (less than full release) -> exactly one.
